// File: rtl/upsizing_rr_arbiter_if.sv
// upsizing_rr_arbiter_if: narrow source streams in, one tagged narrow stream out to the upsizer.
interface upsizing_rr_arbiter_if #(
    parameter int N_SRC = 4,
    parameter int n     = 5
);
    localparam int nb = n * 8;
    localparam int IW = $clog2(N_SRC);

    logic [N_SRC*nb-1:0] s_tdata;
    logic [N_SRC-1:0]    s_tvalid;
    logic [N_SRC-1:0]    s_tready;
    logic [nb-1:0]       m_tdata;
    logic                m_tvalid;
    logic                m_tready;
    logic [IW-1:0]       m_tid;
    logic                busy;

    modport master (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tid, busy
    );

    modport slave (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tid, busy
    );
endinterface

// File: rtl/upsizing_rr_arbiter.sv
// upsizing_rr_arbiter: round-robin arbiter holding each grant for two accepted beats
// so both halves of an upsized word come from one source.
module upsizing_rr_arbiter #(
    parameter int N_SRC = 4,
    parameter int n     = 5
) (
    input logic                  aclk,
    input logic                  areset,
    upsizing_rr_arbiter_if.master bus
);
    localparam int nb = n * 8;
    localparam int IW = $clog2(N_SRC);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FIRST  = 2'd1;
    localparam logic [1:0] SECOND = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, last_q, last_d;
    logic [IW-1:0] base, win, c;
    logic          any, busy, fire;

    assign busy = state_q != IDLE;
    assign fire = bus.m_tvalid & bus.m_tready;

    // On the final beat the current grant becomes lowest priority for re-arbitration.
    always_comb begin
        base = (state_q == SECOND) ? grant_q : last_q;
        win  = '0;
        any  = 1'b0;
        c    = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            c = IW'((int'(base) + k) % N_SRC);
            if (bus.s_tvalid[c]) begin
                win = c;
                any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (any ? FIRST : IDLE) :
                  !fire ? state_q :
                  (state_q == FIRST) ? SECOND : (any ? FIRST : IDLE);
        grant_d = (((state_q == IDLE) || (state_q == SECOND && fire)) && any) ? win : grant_q;
        last_d  = (state_q == SECOND && fire) ? grant_q : last_q;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_SRC - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign bus.m_tdata  = bus.s_tdata[grant_q*nb +: nb];
    assign bus.m_tvalid = busy & bus.s_tvalid[grant_q];
    assign bus.s_tready = (busy & bus.m_tready) ? (N_SRC'(1) << grant_q) : '0;
    assign bus.m_tid    = grant_q;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_upsizing_rr_arbiter.sv
// tb_upsizing_rr_arbiter: directed checks of a 4-source and a 3-source arbiter.
module tb_upsizing_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    upsizing_rr_arbiter_if #(.N_SRC(4), .n(5)) ia ();
    upsizing_rr_arbiter_if #(.N_SRC(3), .n(5)) ib ();

    upsizing_rr_arbiter #(.N_SRC(4), .n(5)) da (.aclk(clk), .areset(rst), .bus(ia.master));
    upsizing_rr_arbiter #(.N_SRC(3), .n(5)) db (.aclk(clk), .areset(rst), .bus(ib.master));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ia.s_tvalid = '0;
        ia.m_tready = 1'b1;
        ib.s_tvalid = '0;
        ib.m_tready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        ia.s_tdata  = '0;
        ia.s_tvalid = '0;
        ia.m_tready = 1'b0;
        ib.s_tdata  = '0;
        ib.s_tvalid = '0;
        ib.m_tready = 1'b0;
        #1;
        chk("rst_mtvalid", ia.m_tvalid, 0);
        chk("rst_stready", ia.s_tready, 0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_mtid", ia.m_tid, 0);

        // single source 2: beats A then B, then immediately regranted (sole requester)
        do_reset();
        ia.s_tdata[2*40 +: 40] = 40'hA1A2A3A4A5;
        ia.s_tvalid = 4'b0100;
        #1;
        chk("s1_busy_pre", ia.busy, 0);
        chk("s1_mtvalid_pre", ia.m_tvalid, 0);
        @(negedge clk);
        #1;
        chk("s1_busy", ia.busy, 1);
        chk("s1_tid_a", ia.m_tid, 2);
        chk("s1_data_a", ia.m_tdata, 40'hA1A2A3A4A5);
        chk("s1_stready_a", ia.s_tready, 4'b0100);
        @(negedge clk);
        ia.s_tdata[2*40 +: 40] = 40'hB1B2B3B4B5;
        #1;
        chk("s1_tid_b", ia.m_tid, 2);
        chk("s1_data_b", ia.m_tdata, 40'hB1B2B3B4B5);
        chk("s1_mtvalid_b", ia.m_tvalid, 1);
        @(negedge clk);
        #1;
        chk("s1_regrant_busy", ia.busy, 1);
        chk("s1_regrant_tid", ia.m_tid, 2);

        // all four sources continuous
        do_reset();
        for (int i = 0; i < 4; i++) ia.s_tdata[i*40 +: 40] = 40'(64'h10 * (i + 1));
        ia.s_tvalid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("s2_tid", ia.m_tid, (i / 2) % 4);
            chk("s2_mtvalid", ia.m_tvalid, 1);
            chk("s2_data", ia.m_tdata, 64'h10 * ((i / 2) % 4 + 1));
            chk("s2_stready", ia.s_tready, 4'b0001 << ((i / 2) % 4));
        end

        // source 1 stalled in its second beat while source 3 requests
        do_reset();
        ia.s_tvalid = 4'b0010;
        @(negedge clk);
        #1;
        chk("s3_tid_first", ia.m_tid, 1);
        @(negedge clk);
        ia.m_tready = 1'b0;
        ia.s_tvalid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s3_stall_tid", ia.m_tid, 1);
            chk("s3_stall_stready", ia.s_tready, 0);
            chk("s3_stall_busy", ia.busy, 1);
            @(negedge clk);
        end
        ia.m_tready = 1'b1;
        #1;
        chk("s3_resume_stready", ia.s_tready, 4'b0010);
        chk("s3_resume_tid", ia.m_tid, 1);
        @(negedge clk);
        #1;
        chk("s3_next_tid", ia.m_tid, 3);
        chk("s3_next_stready", ia.s_tready, 4'b1000);

        // asynchronous reset while in the second beat
        do_reset();
        ia.s_tvalid = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("s4_pre_busy", ia.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("s4_rst_busy", ia.busy, 0);
        chk("s4_rst_mtvalid", ia.m_tvalid, 0);
        chk("s4_rst_stready", ia.s_tready, 0);
        @(negedge clk);
        rst = 1'b0;
        ia.s_tvalid = 4'b1001;
        @(negedge clk);
        #1;
        chk("s4_win_tid", ia.m_tid, 0);
        chk("s4_win_busy", ia.busy, 1);

        // only source 2, back-to-back pairs
        do_reset();
        ia.s_tvalid = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("s5_tid", ia.m_tid, 2);
            chk("s5_busy", ia.busy, 1);
            chk("s5_mtvalid", ia.m_tvalid, 1);
        end

        // three sources, 0 and 2 requesting
        do_reset();
        ib.s_tvalid = 3'b101;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("s6_tid", ib.m_tid, (i == 2 || i == 3) ? 2 : 0);
            chk("s6_mtvalid", ib.m_tvalid, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
